hsv_color_tracker: RTL

- Downstream consumer of the RGB-to-HSV stage.
- Classifies each incoming HSV pixel against programmable hue, saturation and value thresholds, and emits a registered binary mask.
- Accumulates the matching pixels over a frame and, at end of frame, computes the object centroid with a multi-cycle divider.
- Feeds the tracking/control logic with one centroid result per frame.

---
 rtl/hsv_track_pkg.sv | 21 ++
 rtl/hsv_track_div.sv | 66 ++++++
 rtl/hsv_color_tracker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hsv_track_pkg.sv
// Shared definitions for the HSV colour tracker: HSV field positions,
// result-path state encoding and the hue window test.
package hsv_track_pkg;

  localparam int H_HI = 31;
  localparam int H_LO = 24;
  localparam int S_HI = 23;
  localparam int S_LO = 16;
  localparam int V_HI = 15;
  localparam int V_LO = 8;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} trk_state_e;

  // Hue window; lo > hi means the window wraps through 0 (red hues).
  function automatic logic hue_in_window(input logic [7:0] h, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (lo <= hi) return (h >= lo) && (h <= hi);
    else          return (h >= lo) || (h <= hi);
  endfunction

endpackage

// File: rtl/hsv_track_div.sv
// Unsigned restoring divider, one quotient bit per cycle, DW cycles per
// division. start_i loads the operands; done_o pulses when quotient_o is final.
module hsv_track_div #(
  parameter int DW = 29,
  parameter int VW = 19,
  parameter int QW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [QW-1:0] quotient_o
);

  localparam int CW = $clog2(DW + 1);

  logic [VW-1:0] rem_q, den_q, diff;
  logic [DW-1:0] quo_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, fits;
  logic [VW:0]   rem_sh;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rem_sh = {rem_q, quo_q[DW-1]};
    fits   = rem_sh >= {1'b0, den_q};
    diff   = rem_sh[VW-1:0] - den_q;
  end

  // Dividend shifts out MSB-first while quotient bits shift in at the bottom.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        quo_q  <= dividend_i;
        den_q  <= divisor_i;
        rem_q  <= '0;
        cnt_q  <= CW'(DW);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= fits ? diff : rem_sh[VW-1:0];
        quo_q <= {quo_q[DW-2:0], fits};
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q[QW-1:0];

endmodule

// File: rtl/hsv_color_tracker.sv
// HSV colour tracker: per-pixel threshold mask, per-frame match accumulation
// and centroid division. Define HSV_TRACK_BBOX_EN to add bounding-box outputs.
module hsv_color_tracker import hsv_track_pkg::*; #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int CNT_W   = 19,
  parameter int MIN_PIX = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             sof,
  input  logic [31:0]      HSV,
  input  logic [7:0]       h_min,
  input  logic [7:0]       h_max,
  input  logic [7:0]       s_min,
  input  logic [7:0]       v_min,
  output logic             mask_out,
  output logic             mask_valid,
  output logic             frame_done,
  output logic             obj_valid,
  output logic [XW-1:0]    obj_x,
  output logic [YW-1:0]    obj_y,
  output logic [CNT_W-1:0] obj_count,
  output logic             overrun
`ifdef HSV_TRACK_BBOX_EN
  ,
  output logic [XW-1:0]    bb_xmin,
  output logic [XW-1:0]    bb_xmax,
  output logic [YW-1:0]    bb_ymin,
  output logic [YW-1:0]    bb_ymax
`endif
);

  // Both dividers share the x width so they finish on the same cycle (YW <= XW).
  localparam int SXW = XW + CNT_W;
  localparam int SYW = YW + CNT_W;

  trk_state_e       state_q;
  logic [XW-1:0]    x_q, x_d, px, qx, obj_x_q;
  logic [YW-1:0]    y_q, y_d, py, qy, obj_y_q;
  logic [CNT_W-1:0] cnt_q, cnt_acc, cnt_snap_q, obj_count_q;
  logic [SXW-1:0]   sx_q, sx_acc;
  logic [SYW-1:0]   sy_q, sy_acc;
  logic             match, eof, big, accept, div_fin;
  logic             mask_q, mvalid_q, done_q, valid_q, ovr_q;
  logic             dx_busy, dy_busy, dx_done, dy_done, unused_sink;

  // Classify, locate the pixel and form the accumulator values including it.
  always_comb begin
    match = hue_in_window(HSV[H_HI:H_LO], h_min, h_max) &&
            (HSV[S_HI:S_LO] >= s_min) && (HSV[V_HI:V_LO] >= v_min);
    px  = sof ? '0 : x_q;
    py  = sof ? '0 : y_q;
    eof = clk_en && (px == XW'(IMG_W - 1)) && (py == YW'(IMG_H - 1));
    if (px == XW'(IMG_W - 1)) begin
      x_d = '0;
      y_d = (py == YW'(IMG_H - 1)) ? '0 : py + YW'(1);
    end else begin
      x_d = px + XW'(1);
      y_d = py;
    end
    cnt_acc = sof ? '0 : cnt_q;
    sx_acc  = sof ? '0 : sx_q;
    sy_acc  = sof ? '0 : sy_q;
    if (match) begin
      cnt_acc = cnt_acc + CNT_W'(1);
      sx_acc  = sx_acc + SXW'(px);
      sy_acc  = sy_acc + SYW'(py);
    end
    big    = cnt_acc >= CNT_W'(MIN_PIX);
    accept = eof && (state_q == IDLE);
  end

  // Registered mask, one cycle behind the sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q   <= 1'b0;
      mvalid_q <= 1'b0;
    end else begin
      mask_q   <= clk_en & match;
      mvalid_q <= clk_en;
    end
  end

  // Position and accumulators; end of frame hands off and starts afresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else if (clk_en) begin
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= eof ? '0 : cnt_acc;
      sx_q  <= eof ? '0 : sx_acc;
      sy_q  <= eof ? '0 : sy_acc;
    end
  end

  hsv_track_div #(.DW(SXW), .VW(CNT_W), .QW(XW)) u_div_x (
    .clk_i(clk), .rst_ni(rst), .start_i(accept && big), .dividend_i(sx_acc),
    .divisor_i(cnt_acc), .busy_o(dx_busy), .done_o(dx_done), .quotient_o(qx)
  );

  hsv_track_div #(.DW(SXW), .VW(CNT_W), .QW(YW)) u_div_y (
    .clk_i(clk), .rst_ni(rst), .start_i(accept && big), .dividend_i(SXW'(sy_acc)),
    .divisor_i(cnt_acc), .busy_o(dy_busy), .done_o(dy_done), .quotient_o(qy)
  );

  assign div_fin     = dx_done & dy_done;
  assign unused_sink = ^{HSV[7:0], dx_busy, dy_busy};

  // Result FSM; a frame ending while a result is pending is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      obj_x_q     <= '0;
      obj_y_q     <= '0;
      obj_count_q <= '0;
      cnt_snap_q  <= '0;
      ovr_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (eof && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (eof) begin
          cnt_snap_q <= cnt_acc;
          if (big) state_q <= DIVIDE;
          else begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            valid_q     <= 1'b0;
            obj_x_q     <= '0;
            obj_y_q     <= '0;
            obj_count_q <= cnt_acc;
          end
        end
        DIVIDE: if (div_fin) begin
          state_q     <= DONE;
          done_q      <= 1'b1;
          valid_q     <= 1'b1;
          obj_x_q     <= qx;
          obj_y_q     <= qy;
          obj_count_q <= cnt_snap_q;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mask_out   = mask_q;
  assign mask_valid = mvalid_q;
  assign frame_done = done_q;
  assign obj_valid  = valid_q;
  assign obj_x      = obj_x_q;
  assign obj_y      = obj_y_q;
  assign obj_count  = obj_count_q;
  assign overrun    = ovr_q;

`ifdef HSV_TRACK_BBOX_EN
  logic [XW-1:0] bxn_q, bxx_q, bxn_acc, bxx_acc, bxn_s_q, bxx_s_q, bxn_o_q, bxx_o_q;
  logic [YW-1:0] byn_q, byx_q, byn_acc, byx_acc, byn_s_q, byx_s_q, byn_o_q, byx_o_q;

  // Running extents including the current pixel.
  always_comb begin
    bxn_acc = sof ? '1 : bxn_q;
    bxx_acc = sof ? '0 : bxx_q;
    byn_acc = sof ? '1 : byn_q;
    byx_acc = sof ? '0 : byx_q;
    if (match) begin
      if (px < bxn_acc) bxn_acc = px;
      if (px > bxx_acc) bxx_acc = px;
      if (py < byn_acc) byn_acc = py;
      if (py > byx_acc) byx_acc = py;
    end
  end

  // Track extents, snapshot at frame end, publish alongside the centroid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bxn_q <= '1; bxx_q <= '0; byn_q <= '1; byx_q <= '0;
      bxn_s_q <= '0; bxx_s_q <= '0; byn_s_q <= '0; byx_s_q <= '0;
      bxn_o_q <= '0; bxx_o_q <= '0; byn_o_q <= '0; byx_o_q <= '0;
    end else begin
      if (clk_en) begin
        bxn_q <= eof ? '1 : bxn_acc;
        bxx_q <= eof ? '0 : bxx_acc;
        byn_q <= eof ? '1 : byn_acc;
        byx_q <= eof ? '0 : byx_acc;
      end
      if (accept) begin
        bxn_s_q <= bxn_acc; bxx_s_q <= bxx_acc; byn_s_q <= byn_acc; byx_s_q <= byx_acc;
      end
      if (accept && !big) begin
        bxn_o_q <= '0; bxx_o_q <= '0; byn_o_q <= '0; byx_o_q <= '0;
      end else if (state_q == DIVIDE && div_fin) begin
        bxn_o_q <= bxn_s_q; bxx_o_q <= bxx_s_q; byn_o_q <= byn_s_q; byx_o_q <= byx_s_q;
      end
    end
  end

  assign bb_xmin = bxn_o_q;
  assign bb_xmax = bxx_o_q;
  assign bb_ymin = byn_o_q;
  assign bb_ymax = byx_o_q;
`endif

endmodule
